// File: rtl/prog_encoder.sv
// -----------------------------------------------------------------------------
// prog_encoder
//
// Sequential RV32I instruction encoder and program writer. One symbolic
// instruction (mnemonic, register indices, immediate) is accepted per
// handshake, range-checked, packed into its 32-bit machine word and written
// into instruction memory at an auto-incrementing word address.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   instruction fields valid
//   in_ready   encoder can accept fields this cycle (IDLE only)
//   in_last    accompanying instruction is the final one of the program
//   mnem       0 ADD,1 SUB,2 AND,3 OR,4 ADDI,5 SLLI,6 XORI,7 SRLI,8 ANDI,
//              9 LUI,10 AUIPC,11 LW,12 SW,13 BEQ,14 BNE,15 JAL,16 JALR
//   rd/rs1/rs2 register indices
//   imm        signed immediate (LUI/AUIPC: 20-bit upper value, right-aligned)
//   mem_we     instruction-memory write strobe (one cycle per word)
//   mem_addr   word address of the write
//   mem_wdata  encoded instruction word
//   count      number of words issued to memory
//   err        sticky: at least one instruction was rejected
//   done       program complete or memory full; left only through rst
// -----------------------------------------------------------------------------
module prog_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [4:0]            mnem,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err,
    output logic                  done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    // Count value reached after the last free word has been written.
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]  state;
    logic        last_q;
    logic [31:0] enc_word;
    logic        enc_legal;

    // Range checks expressed as "upper bits are a pure sign extension".
    logic fits_i, fits_b, fits_j, fits_shamt, fits_u;

    assign fits_i     = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_b     = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign fits_j     = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    assign fits_shamt = ~(|imm[31:5]);
    assign fits_u     = ~(|imm[31:20]);

    // NOTE: every output of this always_comb gets a default before the case,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (mnem)
            5'd0: begin  // ADD
                enc_word  = {7'h00, rs2, rs1, 3'd0, rd, OP_R};
                enc_legal = 1'b1;
            end
            5'd1: begin  // SUB
                enc_word  = {7'h20, rs2, rs1, 3'd0, rd, OP_R};
                enc_legal = 1'b1;
            end
            5'd2: begin  // AND
                enc_word  = {7'h00, rs2, rs1, 3'd7, rd, OP_R};
                enc_legal = 1'b1;
            end
            5'd3: begin  // OR
                enc_word  = {7'h00, rs2, rs1, 3'd6, rd, OP_R};
                enc_legal = 1'b1;
            end
            5'd4: begin  // ADDI
                enc_word  = {imm[11:0], rs1, 3'd0, rd, OP_IMM};
                enc_legal = fits_i;
            end
            5'd5: begin  // SLLI
                enc_word  = {7'h00, imm[4:0], rs1, 3'd1, rd, OP_IMM};
                enc_legal = fits_shamt;
            end
            5'd6: begin  // XORI
                enc_word  = {imm[11:0], rs1, 3'd4, rd, OP_IMM};
                enc_legal = fits_i;
            end
            5'd7: begin  // SRLI
                enc_word  = {7'h00, imm[4:0], rs1, 3'd5, rd, OP_IMM};
                enc_legal = fits_shamt;
            end
            5'd8: begin  // ANDI
                enc_word  = {imm[11:0], rs1, 3'd7, rd, OP_IMM};
                enc_legal = fits_i;
            end
            5'd9: begin  // LUI
                enc_word  = {imm[19:0], rd, OP_LUI};
                enc_legal = fits_u;
            end
            5'd10: begin  // AUIPC
                enc_word  = {imm[19:0], rd, OP_AUIPC};
                enc_legal = fits_u;
            end
            5'd11: begin  // LW
                enc_word  = {imm[11:0], rs1, 3'd2, rd, OP_LOAD};
                enc_legal = fits_i;
            end
            5'd12: begin  // SW
                enc_word  = {imm[11:5], rs2, rs1, 3'd2, imm[4:0], OP_STORE};
                enc_legal = fits_i;
            end
            5'd13: begin  // BEQ
                enc_word  = {imm[12], imm[10:5], rs2, rs1, 3'd0,
                             imm[4:1], imm[11], OP_BRANCH};
                enc_legal = fits_b;
            end
            5'd14: begin  // BNE
                enc_word  = {imm[12], imm[10:5], rs2, rs1, 3'd1,
                             imm[4:1], imm[11], OP_BRANCH};
                enc_legal = fits_b;
            end
            5'd15: begin  // JAL
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                enc_legal = fits_j;
            end
            5'd16: begin  // JALR
                enc_word  = {imm[11:0], rs1, 3'd0, rd, OP_JALR};
                enc_legal = fits_i;
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            last_q    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (enc_legal) begin
                            // Address and word are captured now so they are
                            // stable for the whole WRITE cycle and then hold.
                            mem_addr  <= count[ADDR_WIDTH-1:0];
                            mem_wdata <= enc_word;
                            count     <= count + 1'b1;
                            last_q    <= in_last;
                            state     <= S_WRITE;
                        end else begin
                            err <= 1'b1;
                            if (in_last) begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    // count already includes the word being written.
                    if (last_q || (count == FULL_COUNT)) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The strobe is qualified by rst so a reset landing in the WRITE cycle
    // keeps the pending word out of memory.
    assign mem_we   = (state == S_WRITE) && !rst;
    assign in_ready = (state == S_IDLE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_prog_encoder.sv
// -----------------------------------------------------------------------------
// tb_prog_encoder
//
// Drives two prog_encoder instances (ADDR_WIDTH 8 and 2) with the same
// stimulus. A behavioural model per instance predicts every output each
// cycle; directed sequences pin the model and DUT to hand-computed words.
// -----------------------------------------------------------------------------
module tb_prog_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [4:0]  mnem = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;

    logic        rdy8, we8, err8, done8;
    logic [7:0]  addr8;
    logic [31:0] wdata8;
    logic [8:0]  cnt8;
    logic        rdy2, we2, err2, done2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  cnt2;

    prog_encoder #(.ADDR_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .in_last(in_last), .mnem(mnem), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8),
        .count(cnt8), .err(err8), .done(done8)
    );

    prog_encoder #(.ADDR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .in_last(in_last), .mnem(mnem), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
        .count(cnt2), .err(err2), .done(done2)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference encoder: field placement from the RV32I format tables,
    // range checks as plain integer bounds.
    // ---------------------------------------------------------------------
    function automatic bit [31:0] ref_word(input int m, input int d, input int s1,
                                           input int s2, input int v, output bit ok);
        bit [31:0] u;
        bit [31:0] w;
        int f3;
        int f7;
        u  = v;
        w  = 0;
        ok = 1'b0;
        f3 = 0;
        f7 = 0;
        case (m)
            0, 1, 2, 3: begin
                f3 = (m == 2) ? 7 : (m == 3) ? 6 : 0;
                f7 = (m == 1) ? 32 : 0;
                w  = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h33;
                ok = 1'b1;
            end
            4, 6, 8, 11, 16: begin
                f3 = (m == 6) ? 4 : (m == 8) ? 7 : (m == 11) ? 2 : 0;
                w  = ((u & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7);
                w  = w | ((m == 11) ? 32'h03 : (m == 16) ? 32'h67 : 32'h13);
                ok = (v >= -2048) && (v <= 2047);
            end
            5, 7: begin
                f3 = (m == 5) ? 1 : 5;
                w  = ((u & 31) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
                ok = (v >= 0) && (v <= 31);
            end
            9, 10: begin
                w  = ((u & 32'hFFFFF) << 12) | (d << 7) | ((m == 9) ? 32'h37 : 32'h17);
                ok = (v >= 0) && (v <= 1048575);
            end
            12: begin
                w  = (((u >> 5) & 127) << 25) | (s2 << 20) | (s1 << 15) | (2 << 12)
                   | ((u & 31) << 7) | 32'h23;
                ok = (v >= -2048) && (v <= 2047);
            end
            13, 14: begin
                f3 = m - 13;
                w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (s2 << 20)
                   | (s1 << 15) | (f3 << 12) | (((u >> 1) & 15) << 8)
                   | (((u >> 11) & 1) << 7) | 32'h63;
                ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            end
            15: begin
                w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21)
                   | (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12) | (d << 7) | 32'h6F;
                ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            end
            default: begin
                w  = 0;
                ok = 1'b0;
            end
        endcase
        return w;
    endfunction

    // ---------------------------------------------------------------------
    // Behavioural model, one per capacity. busy = a word is being written
    // this cycle; fin = program finished or memory full.
    // ---------------------------------------------------------------------
    int        cap   [2] = '{256, 4};
    bit        m_busy[2];
    bit        m_fin [2];
    bit        m_err [2];
    bit        m_last[2];
    int        m_cnt [2];
    int        m_addr[2];
    bit [31:0] m_wdata[2];

    always @(posedge clk) begin
        bit        ok;
        bit [31:0] w;
        w = ref_word(int'(mnem), int'(rd), int'(rs1), int'(rs2), int'($signed(imm)), ok);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 0; m_fin[k] = 0; m_err[k] = 0; m_last[k] = 0;
                m_cnt[k] = 0; m_addr[k] = 0; m_wdata[k] = 0;
            end else if (m_busy[k]) begin
                m_busy[k] = 0;
                if (m_last[k] || m_cnt[k] == cap[k]) m_fin[k] = 1;
            end else if (!m_fin[k] && in_valid) begin
                if (ok) begin
                    m_busy[k]  = 1;
                    m_addr[k]  = m_cnt[k];
                    m_wdata[k] = w;
                    m_cnt[k]   = m_cnt[k] + 1;
                    m_last[k]  = in_last;
                end else begin
                    m_err[k] = 1;
                    if (in_last) m_fin[k] = 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("w8.in_ready",  32'(rdy8),   32'(!m_busy[0] && !m_fin[0]));
            check("w8.mem_we",    32'(we8),    32'(m_busy[0] && !rst));
            check("w8.mem_addr",  32'(addr8),  32'(m_addr[0]));
            check("w8.mem_wdata", wdata8,      m_wdata[0]);
            check("w8.count",     32'(cnt8),   32'(m_cnt[0]));
            check("w8.err",       32'(err8),   32'(m_err[0]));
            check("w8.done",      32'(done8),  32'(m_fin[0]));
            check("w2.in_ready",  32'(rdy2),   32'(!m_busy[1] && !m_fin[1]));
            check("w2.mem_we",    32'(we2),    32'(m_busy[1] && !rst));
            check("w2.mem_addr",  32'(addr2),  32'(m_addr[1]));
            check("w2.mem_wdata", wdata2,      m_wdata[1]);
            check("w2.count",     32'(cnt2),   32'(m_cnt[1]));
            check("w2.err",       32'(err2),   32'(m_err[1]));
            check("w2.done",      32'(done2),  32'(m_fin[1]));
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after a rising edge.
    // ---------------------------------------------------------------------
    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents one instruction and holds it until the width-8 instance
    // takes it, within a bounded number of cycles.
    task automatic send(input int m, input int d, input int s1, input int s2,
                        input int v, input bit last);
        bit acc;
        acc      = 1'b0;
        mnem     = 5'(m);
        rd       = 5'(d);
        rs1      = 5'(s1);
        rs2      = 5'(s2);
        imm      = 32'(v);
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = rdy8;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) check("send.accept_timeout", 32'(acc), 32'd1);
    endtask

    function automatic int rand_imm();
        int edges[20] = '{-1048578, -1048577, -1048576, 1048574, 1048575, -4097,
                          -4096, 4094, 4095, 4096, -2049, -2048, 2047, 2048,
                          -1, 0, 31, 32, 1048576, 3};
        case ($urandom_range(0, 5))
            0:       return int'($urandom);
            1:       return int'($urandom_range(0, 63)) - 32;
            2:       return edges[$urandom_range(0, 19)];
            3:       return int'($urandom_range(0, 4095)) - 2048;
            4:       return int'($urandom_range(0, 2097151)) - 1048576;
            default: return int'($urandom_range(0, 2097151));
        endcase
    endfunction

    initial begin
        bit        ok;
        bit [31:0] w;
        bit [31:0] words[4] = '{32'h402081B3, 32'hFE209EE3, 32'h008000EF, 32'h123452B7};

        // Model pinned to hand-assembled words.
        w = ref_word(4, 1, 0, 0, 5, ok);          check("model.addi", w, 32'h00500093);
        w = ref_word(14, 0, 1, 2, -4, ok);        check("model.bne", w, 32'hFE209EE3);
        w = ref_word(15, 1, 0, 0, 8, ok);         check("model.jal", w, 32'h008000EF);
        w = ref_word(13, 0, 0, 0, 3, ok);         check("model.beq_odd_ok", 32'(ok), 32'd0);

        do_reset();
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset.in_ready", 32'(rdy8), 32'd1);
        check("reset.count", 32'(cnt8), 32'd0);
        check("reset.mem_wdata", wdata8, 32'd0);

        // Single ADDI: visible in the following cycle.
        send(4, 1, 0, 0, 5, 1'b0);
        @(negedge clk);
        check("addi.mem_we", 32'(we8), 32'd1);
        check("addi.mem_addr", 32'(addr8), 32'd0);
        check("addi.mem_wdata", wdata8, 32'h00500093);
        check("addi.count", 32'(cnt8), 32'd1);

        // Back-to-back program ending with in_last.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: send(1, 3, 1, 2, 0, 1'b0);
                1: send(14, 0, 1, 2, -4, 1'b0);
                2: send(15, 1, 0, 0, 8, 1'b0);
                default: send(9, 5, 0, 0, 32'h12345, 1'b1);
            endcase
            @(negedge clk);
            check("prog.in_ready_low", 32'(rdy8), 32'd0);
            check("prog.mem_addr", 32'(addr8), 32'(i));
            check("prog.mem_wdata", wdata8, words[i]);
        end
        @(negedge clk);
        check("prog.done", 32'(done8), 32'd1);

        // Illegal instructions: nothing written, err sticks.
        do_reset();
        send(13, 0, 1, 2, 3, 1'b0);
        @(negedge clk);
        check("bad.beq_err", 32'(err8), 32'd1);
        check("bad.beq_ready", 32'(rdy8), 32'd1);
        send(4, 1, 0, 0, 2048, 1'b0);
        send(20, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        check("bad.count", 32'(cnt8), 32'd0);
        check("bad.err_sticky", 32'(err8), 32'd1);
        check("bad.ready", 32'(rdy8), 32'd1);

        // Fill the 4-word instance with five ADDIs.
        do_reset();
        for (int i = 0; i < 5; i++) send(4, 1, 1, 0, i, 1'b0);
        repeat (2) @(negedge clk);
        check("full.count2", 32'(cnt2), 32'd4);
        check("full.done2", 32'(done2), 32'd1);
        check("full.addr2", 32'(addr2), 32'd3);
        check("full.count8", 32'(cnt8), 32'd5);

        // Reset during the WRITE cycle suppresses the write.
        do_reset();
        send(4, 2, 0, 0, 7, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rstw.mem_we", 32'(we8), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstw.in_ready", 32'(rdy8), 32'd1);
        check("rstw.count", 32'(cnt8), 32'd0);
        check("rstw.err", 32'(err8), 32'd0);
        check("rstw.done", 32'(done8), 32'd0);

        // Randomised traffic with occasional resets.
        @(posedge clk);
        #1;
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 79) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_last  = ($urandom_range(0, 24) == 0);
            mnem     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31))
                                                   : 5'($urandom_range(0, 16));
            rd       = 5'($urandom);
            rs1      = 5'($urandom);
            rs2      = 5'($urandom);
            imm      = 32'(rand_imm());
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_encoder.md
# prog_encoder

Sequential RV32I instruction encoder and program writer for the f1_cpu. It accepts one symbolic instruction per handshake (mnemonic, register indices, immediate) and range-checks the fields. It packs each legal instruction into a 32-bit word in the encodings the CPU control decoder consumes, then writes the word into instruction memory at an auto-incrementing word address. It is used by the bench and the boot path to load programs without an external assembler.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2^ADDR_WIDTH words
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  instruction fields valid
- in_ready  output  1  encoder can accept fields this cycle
- in_last  input  1  accompanying instruction is the final one of the program
- mnem  input  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 SLLI, 6 XORI, 7 SRLI, 8 ANDI, 9 LUI, 10 AUIPC, 11 LW, 12 SW, 13 BEQ, 14 BNE, 15 JAL, 16 JALR; 17-31 illegal
- rd, rs1, rs2  input  5 each  register indices (unused fields ignored)
- imm  input  32  signed immediate; for LUI/AUIPC the 20-bit upper value, right-aligned
- mem_we  output  1  instruction-memory write strobe
- mem_addr  output  ADDR_WIDTH  word address of write
- mem_wdata  output  32  encoded instruction
- count  output  ADDR_WIDTH+1  words written so far
- err  output  1  sticky: at least one instruction was rejected
- done  output  1  program complete or memory full

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: in_ready=1. On in_valid, fields are accepted and the word is encoded and registered.
  - Legal: go to WRITE.
  - Illegal: set err and drop the word, with no write and count unchanged. If in_last=1, go to DONE; else stay in IDLE.
- WRITE: in_ready=0, mem_we=1 for exactly one cycle, mem_addr=count[ADDR_WIDTH-1:0], count increments.
  - Next state is DONE if the accepted in_last was 1 or the new count equals 2^ADDR_WIDTH; else IDLE.
- DONE: in_ready=0, mem_we=0, done=1. Exited only by rst.
- Encodings: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
  - R-type, op 0x33: ADD f3=0/f7=0x00; SUB 0/0x20; OR 6/0x00; AND 7/0x00.
  - OP-IMM, op 0x13: ADDI f3=0, SLLI 1, XORI 4, SRLI 5, ANDI 7. SLLI/SRLI use shamt=imm[4:0] with f7=0.
  - LW: op 0x03, f3=2, I-imm. SW: op 0x23, f3=2, S-imm split imm[11:5] into [31:25] and imm[4:0] into [11:7].
  - BEQ/BNE: op 0x63, f3 0/1, B-imm (imm[12|10:5] into [31:25], imm[4:1|11] into [11:7]).
  - LUI: op 0x37. AUIPC: op 0x17. Both place imm[19:0] at [31:12].
  - JAL: op 0x6F, J-imm (imm[20|10:1|11|19:12]). JALR: op 0x67, f3=0, I-imm.
- Range checks (any failure makes the instruction illegal):
  - I/S: -2048..2047.
  - Shifts: 0..31.
  - B: -4096..4094, even.
  - J: -1048576..1048574, even.
  - U: imm[31:20]==0.
  - mnem >= 17.

## Timing
- Reset values: in_ready=1 (state IDLE), mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0, done=0.
- Latency: fields accepted at edge N appear as mem_we/mem_addr/mem_wdata during cycle N+1. Throughput is one word per 2 cycles.
- Handshake: transfer occurs only when in_valid && in_ready at the rising edge. Fields need only be stable in that cycle.
- mem_addr and mem_wdata hold their last value outside WRITE. mem_we is never high in IDLE or DONE.
- Full: after the 2^ADDR_WIDTH-th write, done=1 next cycle. No wrap to address 0. Further in_valid is ignored (in_ready=0).
- Illegal plus in_last in the same transfer: err=1 and done=1 on the following cycle, with no write.
- rst asserted in any state, including mid-WRITE, takes priority: next cycle is reset values, and a pending write is not issued.

## Test plan
- After reset, send ADDI rd=1 rs1=0 imm=5 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00500093, count=1.
- Back-to-back SUB rd=3 rs1=1 rs2=2, BNE rs1=1 rs2=2 imm=-4, JAL rd=1 imm=8, LUI rd=5 imm=0x12345 with in_last on the final one:
  - writes 0x402081B3, 0xFE209EE3, 0x008000EF, 0x123452B7 at addresses 0-3;
  - in_ready low every WRITE cycle; done=1 after the fourth write.
- BEQ imm=3 (odd), then ADDI imm=2048, then mnem=20 -> no writes, count=0, err=1 and stays set, in_ready returns to 1 each time.
- ADDR_WIDTH=2, stream 5 legal ADDI -> 4 writes at addresses 0-3, count=4, done=1, fifth instruction never accepted.
- Assert rst during the WRITE cycle of an ADDI -> that write is suppressed; the next cycle shows in_ready=1, count=0, err=0, done=0.
